// File: rtl/flash_io_pkg.sv
// rtl/flash_io_pkg.sv - shared states and bus byte constants for flash_data_io
// Purpose: state enum, op encodings, command/unlock/terminator bytes and an
// opcode lookup helper. No ports.
package flash_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNLK1,
        ST_UNLK2,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_TERM
    } state_e;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_PROG   = 2'd1;
    localparam logic [1:0] OP_ERASE  = 2'd2;
    localparam logic [1:0] OP_STATUS = 2'd3;

    localparam logic [7:0] OPC_READ   = 8'hC0;
    localparam logic [7:0] OPC_PROG   = 8'hB0;
    localparam logic [7:0] OPC_ERASE  = 8'hD0;
    localparam logic [7:0] OPC_STATUS = 8'hE0;

    localparam logic [7:0] UNLK1_BYTE = 8'hAA;
    localparam logic [7:0] UNLK2_BYTE = 8'h55;
    localparam logic [7:0] TERM_BYTE  = 8'h00;

    function automatic logic [7:0] opcode_of(input logic [1:0] op);
        logic [7:0] opc;
        case (op)
            OP_READ:  opc = OPC_READ;
            OP_PROG:  opc = OPC_PROG;
            OP_ERASE: opc = OPC_ERASE;
            default:  opc = OPC_STATUS;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/flash_io_stall_timer.sv
// rtl/flash_io_stall_timer.sv - consecutive write-stall counter with expiry
// Ports: clk (falling-edge active), reset (sync, active-high), clear (restart
// count), inc (one more stall this cycle), expired (this stall is the
// TIMEOUT-th consecutive one).
module flash_io_stall_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    // Expiry is flagged on the stall that would make the count reach TIMEOUT,
    // so the owner can abort on that same edge.
    assign expired = inc && !clear && (count_q == CW'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear || expired) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flash_data_io.sv
// rtl/flash_data_io.sv - flash command sequencer driving unlock/cmd/addr/data bytes
// Ports: SCL clock (falling edge), Reset sync high; Start/Op/Addr/Len command
// request; WrData/WrValid/WrReady program stream; IOIn read bus; IO/IOOe driven
// bus; RdData/RdValid captured read beat; Busy/Done/Err status.
module flash_data_io
    import flash_io_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_BYTES = 3,
    parameter int BURST_MAX  = 16,
    parameter int TIMEOUT    = 64,
    localparam int LEN_W     = $clog2(BURST_MAX + 1)
) (
    input  logic                    SCL,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [1:0]              Op,
    input  logic [8*ADDR_BYTES-1:0] Addr,
    input  logic [LEN_W-1:0]        Len,
    input  logic [DATA_W-1:0]       WrData,
    input  logic                    WrValid,
    output logic                    WrReady,
    input  logic [DATA_W-1:0]       IOIn,
    output logic [DATA_W-1:0]       IO,
    output logic                    IOOe,
    output logic [DATA_W-1:0]       RdData,
    output logic                    RdValid,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Err
);

    localparam int AIDX_W = $clog2(ADDR_BYTES + 1);

    state_e                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d, beat_q, beat_d, len_eff;
    logic [AIDX_W-1:0]       aidx_q, aidx_d;
    logic [DATA_W-1:0]       io_q, io_d, rd_data_q, rd_data_d;
    logic                    io_oe_q, io_oe_d, rd_valid_q, rd_valid_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [7:0]              addr_byte;
    logic                    addr_last, wr_slot, stall_expired;

    // IO is registered, so every state computes the byte for the next cycle.
    // aidx_q is the index of the address byte to put out next.
    always_comb begin
        addr_byte = '0;
        for (int i = 0; i < ADDR_BYTES; i++) begin
            if (aidx_q == AIDX_W'(i)) begin
                addr_byte = addr_q[8*(ADDR_BYTES-1-i) +: 8];
            end
        end
    end

    always_comb begin
        len_eff = Len;
        if (Op == OP_STATUS || Len == '0) begin
            len_eff = LEN_W'(1);
        end else if (Len > LEN_W'(BURST_MAX)) begin
            len_eff = LEN_W'(BURST_MAX);
        end
    end

    assign addr_last = (state_q == ST_ADDR) && (aidx_q == AIDX_W'(ADDR_BYTES));
    // A write slot is a cycle whose closing edge decides the byte shown in the
    // following WDATA cycle: the last address cycle, or a WDATA cycle with beats left.
    assign wr_slot   = (addr_last && op_q == OP_PROG) ||
                       (state_q == ST_WDATA && beat_q != len_q);
    assign WrReady   = wr_slot;

    flash_io_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall (
        .clk     (SCL),
        .reset   (Reset),
        .clear   ((state_q == ST_IDLE) || (wr_slot && WrValid)),
        .inc     (wr_slot && !WrValid),
        .expired (stall_expired)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        aidx_d     = aidx_q;
        io_d       = io_q;
        io_oe_d    = io_oe_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                io_d    = '0;
                io_oe_d = 1'b0;
                if (Start) begin
                    op_d    = Op;
                    addr_d  = Addr;
                    len_d   = len_eff;
                    beat_d  = '0;
                    aidx_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_UNLK1;
                    io_d    = DATA_W'(UNLK1_BYTE);
                    io_oe_d = 1'b1;
                end
            end
            ST_UNLK1: begin
                state_d = ST_UNLK2;
                io_d    = DATA_W'(UNLK2_BYTE);
            end
            ST_UNLK2: begin
                state_d = ST_CMD;
                io_d    = DATA_W'(opcode_of(op_q));
            end
            ST_CMD: begin
                if (op_q == OP_STATUS) begin
                    state_d = ST_RDATA;
                    io_d    = '0;
                    io_oe_d = 1'b0;
                end else begin
                    state_d = ST_ADDR;
                    io_d    = DATA_W'(addr_byte);
                    aidx_d  = aidx_q + AIDX_W'(1);
                end
            end
            ST_ADDR: begin
                if (!addr_last) begin
                    io_d   = DATA_W'(addr_byte);
                    aidx_d = aidx_q + AIDX_W'(1);
                end else if (op_q == OP_READ) begin
                    state_d = ST_RDATA;
                    io_d    = '0;
                    io_oe_d = 1'b0;
                end else if (op_q == OP_ERASE) begin
                    state_d = ST_TERM;
                    io_d    = DATA_W'(TERM_BYTE);
                end
            end
            ST_WDATA: begin
                if (beat_q == len_q) begin
                    state_d = ST_TERM;
                    io_d    = DATA_W'(TERM_BYTE);
                    io_oe_d = 1'b1;
                end
            end
            ST_RDATA: begin
                rd_data_d  = IOIn;
                rd_valid_d = 1'b1;
                beat_d     = beat_q + LEN_W'(1);
                if (beat_q + LEN_W'(1) == len_q) begin
                    state_d = ST_TERM;
                    io_d    = DATA_W'(TERM_BYTE);
                    io_oe_d = 1'b1;
                end
            end
            ST_TERM: begin
                state_d = ST_IDLE;
                io_d    = '0;
                io_oe_d = 1'b0;
                done_d  = 1'b0 | 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_slot) begin
            if (WrValid) begin
                state_d = ST_WDATA;
                io_d    = WrData;
                io_oe_d = 1'b1;
                beat_d  = beat_q + LEN_W'(1);
            end else if (stall_expired) begin
                state_d = ST_TERM;
                io_d    = DATA_W'(TERM_BYTE);
                io_oe_d = 1'b1;
                err_d   = 1'b1;
            end else begin
                state_d = ST_WDATA;
                io_d    = '0;
                io_oe_d = 1'b0;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(negedge SCL) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            aidx_q     <= '0;
            io_q       <= '0;
            io_oe_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            aidx_q     <= aidx_d;
            io_q       <= io_d;
            io_oe_q    <= io_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign IO      = io_q;
    assign IOOe    = io_oe_q;
    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_flash_data_io.sv
// tb/tb_flash_data_io.sv - scoreboard bench for flash_data_io
module tb_flash_data_io;

    localparam int DATA_W     = 8;
    localparam int ADDR_BYTES = 3;
    localparam int BURST_MAX  = 16;
    localparam int TIMEOUT    = 8;
    localparam int LEN_W      = 5;

    logic              SCL;
    logic              Reset, Start, WrValid, WrReady, IOOe, RdValid, Busy, Done, Err;
    logic [1:0]        Op;
    logic [23:0]       Addr;
    logic [LEN_W-1:0]  Len;
    logic [7:0]        WrData, IOIn, IO, RdData;

    flash_data_io #(
        .DATA_W(DATA_W), .ADDR_BYTES(ADDR_BYTES), .BURST_MAX(BURST_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .SCL(SCL), .Reset(Reset), .Start(Start), .Op(Op), .Addr(Addr), .Len(Len),
        .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady), .IOIn(IOIn),
        .IO(IO), .IOOe(IOOe), .RdData(RdData), .RdValid(RdValid),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    initial SCL = 1'b1;
    always #5 SCL = ~SCL;

    typedef struct {
        logic [7:0] io;
        logic       oe;
        logic       busy;
        logic       done;
        logic       err;
        logic       rdv;
        logic [7:0] rdd;
        logic       rdy;
        logic       wrv;
        logic [7:0] wrd;
        logic [7:0] iin;
    } cyc_t;

    cyc_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic       m_err    = 1'b0;
    logic [7:0] m_rdd    = 8'h00;
    logic       pend_rdv = 1'b0;
    logic [7:0] pend_rdd = 8'h00;
    logic [7:0] rd_pat[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] data_of(input int i);
        logic [31:0] t;
        t = 32'h11 * (i + 1);
        return t[7:0];
    endfunction

    task automatic push(input logic [7:0] io, input logic oe, input logic busy, input logic done);
        cyc_t e;
        e.io = io; e.oe = oe; e.busy = busy; e.done = done; e.err = m_err;
        e.rdv = pend_rdv;
        if (pend_rdv) m_rdd = pend_rdd;
        e.rdd = m_rdd;
        pend_rdv = 1'b0;
        e.rdy = 1'b0; e.wrv = 1'b0; e.wrd = 8'h00; e.iin = 8'h00;
        sb.push_back(e);
    endtask

    // Expected per-cycle behaviour for one command, starting with the cycle
    // right after the Start edge.
    task automatic model_cmd(input logic [1:0] op, input logic [23:0] addr,
                             input logic [4:0] len, input logic [63:0] wv);
        int n, beats, stalls, slot, li;
        logic fin;
        logic [7:0] opc;
        n = (len == 0) ? 1 : ((len > BURST_MAX) ? BURST_MAX : int'(len));
        if (op == 2'd3) n = 1;
        m_err = 1'b0;
        push(8'hAA, 1'b1, 1'b1, 1'b0);
        push(8'h55, 1'b1, 1'b1, 1'b0);
        case (op)
            2'd0: opc = 8'hC0;
            2'd1: opc = 8'hB0;
            2'd2: opc = 8'hD0;
            default: opc = 8'hE0;
        endcase
        push(opc, 1'b1, 1'b1, 1'b0);
        if (op != 2'd3) begin
            for (int b = 0; b < 3; b++) push(addr[23-8*b -: 8], 1'b1, 1'b1, 1'b0);
        end
        if (op == 2'd1) begin
            beats = 0; stalls = 0; slot = 0; fin = 1'b0;
            while (!fin && slot < 64) begin
                li = sb.size() - 1;
                sb[li].rdy = 1'b1;
                sb[li].wrv = wv[slot];
                sb[li].wrd = data_of(beats);
                if (wv[slot]) begin
                    push(data_of(beats), 1'b1, 1'b1, 1'b0);
                    beats++;
                    stalls = 0;
                    if (beats == n) fin = 1'b1;
                end else begin
                    stalls++;
                    if (stalls == TIMEOUT) begin
                        m_err = 1'b1;
                        fin = 1'b1;
                    end else begin
                        push(8'h00, 1'b0, 1'b1, 1'b0);
                    end
                end
                slot++;
            end
        end else if (op != 2'd2) begin
            for (int k = 0; k < n; k++) begin
                push(8'h00, 1'b0, 1'b1, 1'b0);
                sb[sb.size()-1].iin = rd_pat[k];
                pend_rdv = 1'b1;
                pend_rdd = rd_pat[k];
            end
        end
        push(8'h00, 1'b1, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b0, 1'b1);
        push(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Called just after a rising edge; DUT state changes on falling edges.
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [23:0] addr,
                           input logic [4:0] len, input logic [63:0] wv);
        cyc_t e;
        int busy_seen, exp_busy;
        busy_seen = 0; exp_busy = 0;
        model_cmd(op, addr, len, wv);
        foreach (sb[i]) if (sb[i].busy) exp_busy++;
        Start = 1'b1; Op = op; Addr = addr; Len = len;
        while (sb.size() > 0) begin
            @(posedge SCL);
            Start = 1'b0;
            e = sb.pop_front();
            chk({name, ".io"},      IO,      e.io);
            chk({name, ".oe"},      IOOe,    e.oe);
            chk({name, ".busy"},    Busy,    e.busy);
            chk({name, ".done"},    Done,    e.done);
            chk({name, ".err"},     Err,     e.err);
            chk({name, ".rdvalid"}, RdValid, e.rdv);
            chk({name, ".rddata"},  RdData,  e.rdd);
            chk({name, ".wrready"}, WrReady, e.rdy);
            if (Busy) busy_seen++;
            WrValid = e.wrv; WrData = e.wrd; IOIn = e.iin;
        end
        chk({name, ".busy_cycles"}, busy_seen, exp_busy);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".io"},      IO,      8'h00);
        chk({name, ".oe"},      IOOe,    1'b0);
        chk({name, ".wrready"}, WrReady, 1'b0);
        chk({name, ".rddata"},  RdData,  8'h00);
        chk({name, ".rdvalid"}, RdValid, 1'b0);
        chk({name, ".busy"},    Busy,    1'b0);
        chk({name, ".done"},    Done,    1'b0);
        chk({name, ".err"},     Err,     1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 2'd0; Addr = 24'h0; Len = '0;
        WrData = 8'h00; WrValid = 1'b0; IOIn = 8'h00;
        rd_pat[0] = 8'h5A; rd_pat[1] = 8'hA5; rd_pat[2] = 8'h3C; rd_pat[3] = 8'h00;
        repeat (3) @(posedge SCL);
        chk_all_zero("reset");
        Reset = 1'b0;
        @(posedge SCL);

        run_cmd("prog2", 2'd1, 24'h012345, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_cmd("read3", 2'd0, 24'h0A0B0C, 5'd3, 64'h0);
        rd_pat[0] = 8'h96;
        run_cmd("status", 2'd3, 24'h777777, 5'd9, 64'h0);
        run_cmd("timeout", 2'd1, 24'h100000, 5'd1, 64'h0);
        run_cmd("stallclr", 2'd1, 24'hC0FFEE, 5'd3, 64'h0000_0000_0001_8080);
        run_cmd("erase", 2'd2, 24'h00FF00, 5'd4, 64'h0);
        run_cmd("len0", 2'd1, 24'h000001, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_cmd("lenmax", 2'd1, 24'h000002, 5'd21, 64'hFFFF_FFFF_FFFF_FFFF);

        // Erase aborted by reset in ADDR; a Start while busy must be ignored,
        // and reset wins over a simultaneous Start.
        Start = 1'b1; Op = 2'd2; Addr = 24'hABCDEF; Len = 5'd1;
        @(posedge SCL);
        chk("abort.unlk1", IO, 8'hAA);
        Start = 1'b1; Op = 2'd0;
        @(posedge SCL);
        chk("abort.unlk2", IO, 8'h55);
        Start = 1'b0;
        @(posedge SCL);
        chk("abort.cmd_ignores_busy_start", IO, 8'hD0);
        @(posedge SCL);
        chk("abort.addr0", IO, 8'hAB);
        chk("abort.busy", Busy, 1'b1);
        Reset = 1'b1; Start = 1'b1; Op = 2'd1;
        @(posedge SCL);
        chk_all_zero("abort.reset");
        Reset = 1'b0; Start = 1'b0;
        @(posedge SCL);
        chk("abort.no_done", Done, 1'b0);
        chk("abort.idle_busy", Busy, 1'b0);
        chk("abort.idle_io", IO, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_data_io.md
FLASH_DATA_IO -- requirements
Module: flash_data_io

Interface
REQ-001 Parameter DATA_W, default 8, meaning IO/data byte-lane width; SHALL be >= 8.
REQ-002 Parameter ADDR_BYTES, default 3, meaning number of address bytes sent per command.
REQ-003 Parameter BURST_MAX, default 16, meaning maximum data beats per command.
REQ-004 Parameter TIMEOUT, default 64, meaning max consecutive write-stall cycles before abort.
REQ-005 One clock; reset is synchronous and active-high. Ports SCL (clock) and Reset follow this rule.
REQ-006 SCL  in  1  sole clock; all state updates on its falling edge.
REQ-007 Reset  in  1  synchronous active-high reset.
REQ-008 Start  in  1  command request, sampled only in IDLE.
REQ-009 Op  in  2  0=read, 1=program, 2=erase, 3=status.
REQ-010 Addr  in  8*ADDR_BYTES  flash address, latched at Start.
REQ-011 Len  in  clog2(BURST_MAX+1)  data beat count, latched at Start.
REQ-012 WrData  in  DATA_W  program data.
REQ-013 WrValid  in  1  WrData valid.
REQ-014 WrReady  out  1  beat accepted when WrValid&&WrReady.
REQ-015 IOIn  in  DATA_W  bus input sampled during read beats.
REQ-016 IO  out  DATA_W  driven bus byte.
REQ-017 IOOe  out  1  IO output enable.
REQ-018 RdData  out  DATA_W  captured read byte; RdValid  out  1  one-cycle qualifier.
REQ-019 Busy  out  1  high when not IDLE; Done  out  1  one-cycle completion pulse; Err  out  1  sticky abort flag.

Function
REQ-020 States SHALL be IDLE, UNLK1, UNLK2, CMD, ADDR, WDATA, RDATA, TERM.
REQ-021 IDLE with Start=1 SHALL latch Op/Addr/Len, clear Err, enter UNLK1 on the same edge; Start while Busy SHALL be ignored.
REQ-022 Registered IO per state: UNLK1 0xAA, UNLK2 0x55, CMD opcode (read 0xC0, program 0xB0, erase 0xD0, status 0xE0), TERM 0x00; constants zero-extended to DATA_W.
REQ-023 UNLK1->UNLK2->CMD SHALL take exactly one cycle each.
REQ-024 CMD SHALL go to ADDR for Op 0/1/2 and to RDATA (single beat, Len ignored) for Op 3.
REQ-025 ADDR SHALL emit ADDR_BYTES bytes, MSB first, one per cycle, in IO[7:0], upper bits zero.
REQ-026 After ADDR: Op0->RDATA, Op1->WDATA, Op2->TERM.
REQ-027 Len=0 SHALL be treated as 1; Len>BURST_MAX SHALL be clamped to BURST_MAX.
REQ-028 WDATA: WrReady=1; on WrValid=1, IO<=WrData, beat count increments; on WrValid=0, IO holds 0x00 with IOOe=0 and stall counter increments.
REQ-029 Stall counter SHALL clear on every accepted beat; reaching TIMEOUT SHALL set Err and go to TERM.
REQ-030 RDATA: IOOe=0; each cycle RdData<=IOIn, RdValid=1; no stall.
REQ-031 After the last beat SHALL go to TERM; TERM lasts one cycle, then IDLE with Done=1 for exactly one cycle.
REQ-032 IOOe SHALL be 1 in UNLK1, UNLK2, CMD, ADDR, TERM and on accepted WDATA beats; 0 otherwise.
REQ-033 Busy SHALL deassert on the same edge Done asserts.
REQ-034 Err SHALL persist until next accepted Start or Reset.

Reset
REQ-035 Reset SHALL force IDLE, IO=0, IOOe=0, WrReady=0, RdData=0, RdValid=0, Busy=0, Done=0, Err=0, all counters 0.
REQ-036 Reset mid-command SHALL abort without Done, and without TERM byte.
REQ-037 Reset SHALL have priority over Start on the same edge.

Structure
REQ-038 Package flash_io_pkg SHALL hold the state enum, opcode constants (0xB0/0xC0/0xD0/0xE0), unlock constants (0xAA/0x55), terminator 0x00.
REQ-039 Sub-module flash_io_stall_timer (clear, inc, TIMEOUT param, expired output) SHALL implement REQ-029.

Verification
REQ-040 Op=1, Addr=0x012345, Len=2, WrValid held 1, WrData 0x11 then 0x22 -> IO sequence AA,55,B0,01,23,45,11,22,00; Done one cycle later; 9 Busy cycles.
REQ-041 Op=0, Len=3, IOIn 0x5A,0xA5,0x3C -> IO AA,55,C0,addr x3; IOOe=0 for 3 cycles; RdValid three pulses with those bytes.
REQ-042 Op=3 -> AA,55,E0, one RDATA beat, 00, Done; no address bytes.
REQ-043 Op=1, Len=1, WrValid=0 for TIMEOUT cycles -> Err=1, TERM 0x00, Done pulse.
REQ-044 Reset asserted during ADDR of an erase -> next edge IDLE, all outputs zero, no Done; Start during Busy ignored.
REQ-045 Len=0 and Len=BURST_MAX+5 (program) -> exactly 1 and BURST_MAX data beats respectively.
